// File: rtl/trace_packer.sv
// Trace deserializer: packs 1..MAX_TRACES trace bits per beat into WIDTH-bit words,
// queues them in a DEPTH-entry FIFO and releases them only while store permission is held.
module trace_packer #(
    parameter int WIDTH       = 32,
    parameter int MAX_TRACES  = 8,
    parameter int DEPTH       = 4,
    parameter int NTRACE_BITS = $clog2(MAX_TRACES) + 1
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NTRACE_BITS-1:0]   EXP_TRACES_I,
    input  logic                     TRACE_VALID_I,
    input  logic [MAX_TRACES-1:0]    TRACE_I,
    output logic                     TRACE_READY_O,
    input  logic                     FLUSH_I,
    input  logic                     STORE_PERM_I,
    output logic                     STORE_O,
    output logic [WIDTH-1:0]         DATA_O,
    output logic [$clog2(WIDTH):0]   FILL_O
);

    localparam int POS_W   = $clog2(WIDTH) + 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int MAX_EXP = $clog2(MAX_TRACES);

    localparam logic [0:0] S_RUN        = 1'b0;
    localparam logic [0:0] S_FLUSH_WAIT = 1'b1;

    function automatic logic [NTRACE_BITS-1:0] clamp_exp(input logic [NTRACE_BITS-1:0] e);
        if (e > NTRACE_BITS'(MAX_EXP)) begin
            return NTRACE_BITS'(MAX_EXP);
        end
        return e;
    endfunction

    // Packer state
    logic [WIDTH-1:0]       r_pack;
    logic [POS_W-1:0]       r_pos;
    logic [NTRACE_BITS-1:0] r_exp;
    logic [0:0]             r_state;

    // Output FIFO state
    logic [CNT_W-1:0]       r_cnt;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [WIDTH-1:0]       r_mem_data [DEPTH];
    logic [POS_W-1:0]       r_mem_fill [DEPTH];

    logic [POS_W-1:0]       w_n;
    logic [POS_W-1:0]       w_sum;
    logic [POS_W-1:0]       w_pos_nxt;
    logic [POS_W-1:0]       w_push_fill;
    logic [MAX_TRACES-1:0]  w_mask;
    logic [WIDTH-1:0]       w_beat;
    logic [WIDTH-1:0]       w_pack_nxt;
    logic                   w_acc;
    logic                   w_full_word;
    logic                   w_fifo_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_clear;
    logic [0:0]             w_state_nxt;

    assign w_n = POS_W'(1) << r_exp;

    always_comb begin
        for (int i = 0; i < MAX_TRACES; i++) begin
            w_mask[i] = (i < int'(w_n));
        end
    end

    assign w_fifo_full   = (r_cnt == CNT_W'(DEPTH));
    assign TRACE_READY_O = (r_state == S_RUN) && !w_fifo_full && !RST_I;
    assign w_acc         = TRACE_VALID_I && TRACE_READY_O;
    assign w_pop         = STORE_PERM_I && (r_cnt != '0);

    // Pack slots above pos are always zero, so a new beat can simply be OR-ed in.
    assign w_beat      = WIDTH'(TRACE_I & w_mask);
    assign w_pack_nxt  = w_acc ? (r_pack | (w_beat << r_pos)) : r_pack;
    assign w_sum       = r_pos + w_n;
    assign w_pos_nxt   = w_acc ? w_sum : r_pos;
    assign w_full_word = w_acc && (w_sum == POS_W'(WIDTH));
    assign w_push_fill = w_full_word ? POS_W'(WIDTH) : w_pos_nxt;

    always_comb begin
        w_push      = 1'b0;
        w_clear     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_full_word) begin
                    w_push  = 1'b1;
                    w_clear = 1'b1;
                end else if (FLUSH_I && (w_pos_nxt != '0)) begin
                    if (w_fifo_full) begin
                        w_state_nxt = S_FLUSH_WAIT;
                    end else begin
                        w_push  = 1'b1;
                        w_clear = 1'b1;
                    end
                end
            end
            S_FLUSH_WAIT: begin
                // Beats are blocked here, so pack/pos still hold the word to flush.
                if (!w_fifo_full) begin
                    w_push      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_pack   <= '0;
            r_pos    <= '0;
            r_state  <= S_RUN;
            r_exp    <= clamp_exp(EXP_TRACES_I);
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pack  <= w_clear ? '0 : w_pack_nxt;
            r_pos   <= w_clear ? '0 : w_pos_nxt;
            // Width changes only land on word boundaries.
            if (w_clear || (w_pos_nxt == '0)) begin
                r_exp <= clamp_exp(EXP_TRACES_I);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_pack_nxt;
            r_mem_fill[r_wr_ptr] <= w_push_fill;
        end
    end

    assign STORE_O = w_pop;
    assign DATA_O  = (r_cnt != '0) ? r_mem_data[r_rd_ptr] : '0;
    assign FILL_O  = (r_cnt != '0) ? r_mem_fill[r_rd_ptr] : '0;

endmodule

// File: tb/tb_trace_packer.sv
// Bench for trace_packer: directed stimulus, a queue-based reference model checked every
// cycle, and hand-computed literal expectations at key points.
module tb_trace_packer;

    localparam int WIDTH       = 32;
    localparam int MAX_TRACES  = 8;
    localparam int DEPTH       = 4;
    localparam int NTRACE_BITS = 4;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  exp_tr = 4'd0;
    logic        valid  = 1'b0;
    logic [7:0]  trace  = 8'd0;
    logic        flush  = 1'b0;
    logic        perm   = 1'b1;
    logic        ready;
    logic        store;
    logic [31:0] data;
    logic [5:0]  fill;

    int nchecks = 0;
    int nfail   = 0;

    logic [31:0] wl [5];
    logic [31:0] w;

    always #5 clk = ~clk;

    trace_packer #(
        .WIDTH(WIDTH), .MAX_TRACES(MAX_TRACES), .DEPTH(DEPTH), .NTRACE_BITS(NTRACE_BITS)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .EXP_TRACES_I(exp_tr), .TRACE_VALID_I(valid),
        .TRACE_I(trace), .TRACE_READY_O(ready), .FLUSH_I(flush), .STORE_PERM_I(perm),
        .STORE_O(store), .DATA_O(data), .FILL_O(fill)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference model: bits accumulate in a vector, finished words go on a queue.
    typedef struct {
        logic [31:0] d;
        logic [5:0]  f;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_word  = '0;
    int          m_nbits = 0;
    bit          m_fw    = 1'b0;
    int          m_exp   = 0;

    function automatic int clampf(input logic [3:0] e);
        return (e > 4'd3) ? 3 : int'(e);
    endfunction

    always @(negedge clk) begin
        logic        e_ready;
        logic        e_store;
        logic [31:0] e_data;
        logic [5:0]  e_fill;
        bit          was_full;
        int          n;
        e_ready = !rst && !m_fw && (m_q.size() < DEPTH);
        e_store = perm && (m_q.size() > 0);
        e_data  = (m_q.size() > 0) ? m_q[0].d : 32'd0;
        e_fill  = (m_q.size() > 0) ? m_q[0].f : 6'd0;
        chk("mdl_ready", {31'd0, ready}, {31'd0, e_ready});
        chk("mdl_store", {31'd0, store}, {31'd0, e_store});
        chk("mdl_data", data, e_data);
        chk("mdl_fill", {26'd0, fill}, {26'd0, e_fill});
        if (rst) begin
            m_q.delete();
            m_word  = '0;
            m_nbits = 0;
            m_fw    = 1'b0;
            m_exp   = clampf(exp_tr);
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (valid && e_ready) begin
                n = 1 << m_exp;
                for (int i = 0; i < n; i++) m_word[m_nbits + i] = trace[i];
                m_nbits += n;
                if (m_nbits == WIDTH) begin
                    m_q.push_back('{d: m_word, f: 6'd32});
                    m_word  = '0;
                    m_nbits = 0;
                end
            end
            if (!m_fw) begin
                if (flush && m_nbits != 0) begin
                    if (was_full) m_fw = 1'b1;
                    else begin
                        m_q.push_back('{d: m_word, f: 6'(m_nbits)});
                        m_word  = '0;
                        m_nbits = 0;
                    end
                end
            end else if (!was_full) begin
                m_q.push_back('{d: m_word, f: 6'(m_nbits)});
                m_word  = '0;
                m_nbits = 0;
                m_fw    = 1'b0;
            end
            if (e_store) void'(m_q.pop_front());
            if (m_nbits == 0) m_exp = clampf(exp_tr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int k;
        k = 0;
        valid = 1'b1;
        trace = d;
        while (!ready && k < 200) begin
            cyc();
            k++;
        end
        if (k >= 200) begin
            nchecks++;
            nfail++;
            $display("FAIL beat_timeout actual=ready_low required=ready_high");
        end
        cyc();
    endtask

    // Beats b0..b1-1 of word wd at n bits per beat; unused upper lanes get random junk.
    task automatic send_part(input logic [31:0] wd, input int n, input int b0, input int b1);
        logic [31:0] chunk;
        logic [7:0]  msk;
        for (int b = b0; b < b1; b++) begin
            msk   = 8'((1 << n) - 1);
            chunk = (wd >> (b * n)) & 32'(msk);
            send_beat((8'($urandom_range(0, 255)) & ~msk) | chunk[7:0]);
        end
    endtask

    task automatic send_word(input logic [31:0] wd, input int n);
        send_part(wd, n, 0, WIDTH / n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        wl[0] = 32'hA1B2C3D4;
        wl[1] = 32'h0BADF00D;
        wl[2] = 32'hDEADBEEF;
        wl[3] = 32'h12345678;
        wl[4] = 32'hCAFE0042;

        cyc();
        cyc();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_store", {31'd0, store}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_fill", {26'd0, fill}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        cyc();

        // Every width, two random words each, permission held
        for (int e = 0; e < 4; e++) begin
            exp_tr = 4'(e);
            valid  = 1'b0;
            cyc();
            for (int k = 0; k < 2; k++) begin
                w = $urandom();
                send_word(w, 1 << e);
                valid = 1'b0;
                chk($sformatf("w%0d_store", e), {31'd0, store}, 32'd1);
                chk($sformatf("w%0d_data", e), data, w);
                chk($sformatf("w%0d_fill", e), {26'd0, fill}, 32'd32);
                cyc();
            end
        end

        // Out-of-range exponent behaves as 8 traces per beat
        exp_tr = 4'd9;
        valid  = 1'b0;
        cyc();
        send_word(32'h5EC011A7, 8);
        valid = 1'b0;
        chk("clamp_data", data, 32'h5EC011A7);
        cyc();

        // Backpressure: five words with permission withheld
        perm   = 1'b0;
        exp_tr = 4'd3;
        cyc();
        for (int k = 0; k < 4; k++) send_word(wl[k], 8);
        chk("bp_ready_low", {31'd0, ready}, 32'd0);
        chk("bp_no_store", {31'd0, store}, 32'd0);
        valid = 1'b1;
        trace = wl[4][7:0];
        repeat (3) begin
            cyc();
            chk("bp_hold_ready", {31'd0, ready}, 32'd0);
            chk("bp_hold_store", {31'd0, store}, 32'd0);
        end
        perm = 1'b1;
        #1;
        chk("bp_pop0", data, wl[0]);
        chk("bp_pop0_store", {31'd0, store}, 32'd1);
        cyc();
        chk("bp_ready_back", {31'd0, ready}, 32'd1);
        chk("bp_pop1", data, wl[1]);
        cyc();
        trace = wl[4][15:8];
        chk("bp_pop2", data, wl[2]);
        cyc();
        trace = wl[4][23:16];
        chk("bp_pop3", data, wl[3]);
        cyc();
        trace = wl[4][31:24];
        chk("bp_drained", {31'd0, store}, 32'd0);
        cyc();
        valid = 1'b0;
        chk("bp_w5_data", data, wl[4]);
        chk("bp_w5_fill", {26'd0, fill}, 32'd32);
        cyc();

        // Partial-word flush at 4 traces per beat
        exp_tr = 4'd2;
        valid  = 1'b0;
        cyc();
        send_beat(8'h3A);
        send_beat(8'hC5);
        send_beat(8'h7F);
        valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_store", {31'd0, store}, 32'd1);
        chk("fl_data", data, 32'h00000F5A);
        chk("fl_fill", {26'd0, fill}, 32'd12);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_empty_noop", {31'd0, store}, 32'd0);
        cyc();

        // Flush that fills the last FIFO slot while permission is withheld
        perm   = 1'b0;
        exp_tr = 4'd3;
        cyc();
        for (int k = 0; k < 3; k++) send_word(wl[k], 8);
        send_beat(8'h99);
        valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("ff_ready_low", {31'd0, ready}, 32'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("ff_still_low", {31'd0, ready}, 32'd0);
        perm = 1'b1;
        #1;
        chk("ff_pop0", data, wl[0]);
        cyc();
        chk("ff_ready_back", {31'd0, ready}, 32'd1);
        chk("ff_pop1", data, wl[1]);
        cyc();
        chk("ff_pop2", data, wl[2]);
        cyc();
        chk("ff_partial_data", data, 32'h00000099);
        chk("ff_partial_fill", {26'd0, fill}, 32'd8);
        cyc();

        // Width change requested mid-word
        exp_tr = 4'd0;
        cyc();
        w = 32'h9E3779B9;
        send_part(w, 1, 0, 5);
        exp_tr = 4'd3;
        send_part(w, 1, 5, 32);
        valid = 1'b0;
        chk("xw_old_data", data, w);
        chk("xw_old_fill", {26'd0, fill}, 32'd32);
        cyc();
        send_word(32'h0F1E2D3C, 8);
        valid = 1'b0;
        chk("xw_new_data", data, 32'h0F1E2D3C);
        chk("xw_new_store", {31'd0, store}, 32'd1);
        cyc();

        // Reset mid-word with queued words
        perm = 1'b0;
        cyc();
        send_word(wl[3], 8);
        send_word(wl[4], 8);
        send_part(32'h55AA33CC, 8, 0, 2);
        valid = 1'b0;
        rst   = 1'b1;
        cyc();
        rst  = 1'b0;
        perm = 1'b1;
        #1;
        chk("rs_store", {31'd0, store}, 32'd0);
        chk("rs_data", data, 32'd0);
        chk("rs_fill", {26'd0, fill}, 32'd0);
        chk("rs_ready", {31'd0, ready}, 32'd1);
        cyc();
        send_word(32'h600DCAFE, 8);
        valid = 1'b0;
        chk("rs_first_data", data, 32'h600DCAFE);
        chk("rs_first_fill", {26'd0, fill}, 32'd32);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
